// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: state encoding, 2-input truth tables and a width helper shared by
// the gate sweep checker files.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    GC_IDLE   = 2'd0,
    GC_SETTLE = 2'd1,
    GC_SAMPLE = 2'd2,
    GC_DONE   = 2'd3
  } gc_state_e;

  // Bit k is the expected y for input vector k (bit 0 = a, bit 1 = b).
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_XNOR2 = 4'b1001;

  // Bits needed to hold max_val; never less than 1.
  function automatic int gc_cnt_width(input int max_val);
    for (int w = 1; w < 31; w++) begin
      if ((1 << w) > max_val) return w;
    end
    return 31;
  endfunction

endpackage

// File: rtl/gate_sweep_checker_if.sv
// gate_sweep_checker_if: checker-side bundle (control, gate drive, results).
// Carries observed_tt only when GATE_CHK_LOG_EN is defined.
interface gate_sweep_checker_if #(parameter int N_IN = 2);
  import gate_chk_pkg::*;

  logic                   start;
  logic [2**N_IN-1:0]     exp_tt;
  logic [N_IN-1:0]        dut_in;
  logic                   dut_y;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [N_IN:0]          err_count;
  logic [N_IN-1:0]        first_fail_vec;
  logic                   first_fail_valid;
  gc_state_e              dbg_state;
`ifdef GATE_CHK_LOG_EN
  logic [2**N_IN-1:0]     observed_tt;
`endif

  // start is a level sampled only while the checker is idle or done; there is
  // no ready/ack, acceptance is visible as busy rising one cycle later.
`ifdef GATE_CHK_LOG_EN
  modport master (
    output start, exp_tt, dut_y,
    input  dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid,
           dbg_state, observed_tt
  );
  modport slave (
    input  start, exp_tt, dut_y,
    output dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid,
           dbg_state, observed_tt
  );
`else
  modport master (
    output start, exp_tt, dut_y,
    input  dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid,
           dbg_state
  );
  modport slave (
    input  start, exp_tt, dut_y,
    output dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid,
           dbg_state
  );
`endif

endinterface

// File: rtl/gate_chk_settle_timer.sv
// gate_chk_settle_timer: loadable down-counter with a zero flag; counts down only
// while dec_i is high and parks at zero.
module gate_chk_settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives every input vector into a gate, waits SETTLE_CYCLES,
// samples y against a latched truth table. Option macro: GATE_CHK_LOG_EN (observed_tt).
module gate_sweep_checker
  import gate_chk_pkg::*;
#(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  gate_sweep_checker_if.slave bus
);

  localparam int              NV          = 1 << N_IN;
  localparam int              CW          = gc_cnt_width(SETTLE_CYCLES);
  localparam logic [N_IN-1:0] LAST_VEC    = '1;
  localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  gc_state_e        state_q;
  logic [NV-1:0]    tt_q;
  logic [N_IN-1:0]  vec_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [N_IN:0]    err_q, err_d;
  logic [N_IN-1:0]  ffvec_q;
  logic             ffvalid_q;
`ifdef GATE_CHK_LOG_EN
  logic [NV-1:0]    obs_q;
`endif

  logic accept;
  logic mismatch;
  logic last_vec;
  logic tmr_load;
  logic tmr_zero;

  always_comb begin
    accept   = ((state_q == GC_IDLE) || (state_q == GC_DONE)) && bus.start;
    mismatch = (bus.dut_y != tt_q[vec_q]);
    last_vec = (vec_q == LAST_VEC);
    err_d    = err_q;
    if ((state_q == GC_SAMPLE) && mismatch) begin
      err_d = err_q + (N_IN + 1)'(1);
    end
    // Reload on every new vector: sweep start or advancing out of SAMPLE.
    tmr_load = accept || ((state_q == GC_SAMPLE) && !last_vec);
  end

  gate_chk_settle_timer #(.W(CW)) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (SETTLE_LOAD),
    .dec_i      (state_q == GC_SETTLE),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= GC_IDLE;
      tt_q      <= '0;
      vec_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      ffvec_q   <= '0;
      ffvalid_q <= 1'b0;
`ifdef GATE_CHK_LOG_EN
      obs_q     <= '0;
`endif
    end else begin
      case (state_q)
        GC_IDLE, GC_DONE: begin
          if (accept) begin
            tt_q      <= bus.exp_tt;
            vec_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            ffvec_q   <= '0;
            ffvalid_q <= 1'b0;
`ifdef GATE_CHK_LOG_EN
            obs_q     <= '0;
`endif
            state_q   <= GC_SETTLE;
          end
        end
        GC_SETTLE: begin
          if (tmr_zero) state_q <= GC_SAMPLE;
        end
        GC_SAMPLE: begin
          err_q <= err_d;
          if (mismatch && !ffvalid_q) begin
            ffvec_q   <= vec_q;
            ffvalid_q <= 1'b1;
          end
`ifdef GATE_CHK_LOG_EN
          obs_q[vec_q] <= bus.dut_y;
`endif
          // The terminal vector ends the sweep, so vec_q never wraps.
          if (last_vec) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
            state_q <= GC_DONE;
          end else begin
            vec_q   <= vec_q + N_IN'(1);
            state_q <= GC_SETTLE;
          end
        end
        default: state_q <= GC_IDLE;
      endcase
    end
  end

  assign bus.dut_in           = vec_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail_vec   = ffvec_q;
  assign bus.first_fail_valid = ffvalid_q;
  assign bus.dbg_state        = state_q;
`ifdef GATE_CHK_LOG_EN
  assign bus.observed_tt      = obs_q;
`endif

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: directed sweeps against modelled 2- and 3-input gates;
// expected sweep results are queued at start and checked when done rises.
module tb_gate_sweep_checker;
  import gate_chk_pkg::*;

  localparam int W = 35;  // {obs[34:27], latency[26:11], pass[10], ffv[9], ffvec[8:5], err[4:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 100000", $time);
    $fatal(1);
  end

  // ---------------- DUTs and gate models ----------------
  int mode2 = 0;  // 0: xnor gate, 1: xor gate, 2: output stuck at 1

  gate_sweep_checker_if #(.N_IN(2)) bus2 ();
  gate_sweep_checker_if #(.N_IN(3)) bus3 ();

  assign bus2.dut_y = (mode2 == 0) ? ~^bus2.dut_in :
                      (mode2 == 1) ?  ^bus2.dut_in : 1'b1;
  assign bus3.dut_y = &bus3.dut_in;

  gate_sweep_checker #(.N_IN(2), .SETTLE_CYCLES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  gate_sweep_checker #(.N_IN(3), .SETTLE_CYCLES(1)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  logic [W-1:0] exp_q2[$];
  logic [W-1:0] exp_q3[$];
  int   start_cyc2 = 0, start_cyc3 = 0;
  bit   active2 = 0, active3 = 0;
  int   seq_err2 = 0, seq_err3 = 0;
  logic prev_done2 = 1'b0, prev_done3 = 1'b0;

  // dut_in must hold vector k for SETTLE+1 cycles, capped at the terminal vector;
  // done is driven at edge t+NV*(SETTLE+1), so an edge after that sees it.
  always @(negedge clk) begin : mon2
    int m, ev;
    logic [W-1:0] e;
    if (active2) begin
      m  = cyc - start_cyc2;
      ev = (m / 3 > 3) ? 3 : m / 3;
      if (bus2.dut_in !== 2'(ev)) seq_err2++;
    end
    if (bus2.done && !prev_done2) begin
      active2 = 0;
      if (exp_q2.size() == 0) begin
        n_chk++;
        $display("FAIL done2_unexpected: got done=1 required no pending sweep");
      end else begin
        e = exp_q2.pop_front();
        chk("err_count2",        32'(bus2.err_count),        32'(e[4:0]));
        chk("first_fail_vec2",   32'(bus2.first_fail_vec),   32'(e[8:5]));
        chk("first_fail_valid2", 32'(bus2.first_fail_valid), 32'(e[9]));
        chk("pass2",             32'(bus2.pass),             32'(e[10]));
        chk("latency2",          32'(cyc - start_cyc2),      32'(e[26:11]));
        chk("busy_at_done2",     32'(bus2.busy),             32'd0);
        chk("dut_in_seq2",       32'(seq_err2),              32'd0);
`ifdef GATE_CHK_LOG_EN
        chk("observed_tt2",      32'(bus2.observed_tt),      32'(e[34:27]));
`endif
      end
    end
    prev_done2 = bus2.done;
  end

  always @(negedge clk) begin : mon3
    int m, ev;
    logic [W-1:0] e;
    if (active3) begin
      m  = cyc - start_cyc3;
      ev = (m / 2 > 7) ? 7 : m / 2;
      if (bus3.dut_in !== 3'(ev)) seq_err3++;
    end
    if (bus3.done && !prev_done3) begin
      active3 = 0;
      if (exp_q3.size() == 0) begin
        n_chk++;
        $display("FAIL done3_unexpected: got done=1 required no pending sweep");
      end else begin
        e = exp_q3.pop_front();
        chk("err_count3",        32'(bus3.err_count),        32'(e[4:0]));
        chk("first_fail_valid3", 32'(bus3.first_fail_valid), 32'(e[9]));
        chk("pass3",             32'(bus3.pass),             32'(e[10]));
        chk("latency3",          32'(cyc - start_cyc3),      32'(e[26:11]));
        chk("dut_in_seq3",       32'(seq_err3),              32'd0);
`ifdef GATE_CHK_LOG_EN
        chk("observed_tt3",      32'(bus3.observed_tt),      32'(e[34:27]));
`endif
      end
    end
    prev_done3 = bus3.done;
  end

  // ---------------- driver tasks ----------------
  task automatic chk_reset2(input string tag);
    chk({tag, ".dut_in"},           32'(bus2.dut_in),           32'd0);
    chk({tag, ".busy"},             32'(bus2.busy),             32'd0);
    chk({tag, ".done"},             32'(bus2.done),             32'd0);
    chk({tag, ".pass"},             32'(bus2.pass),             32'd0);
    chk({tag, ".err_count"},        32'(bus2.err_count),        32'd0);
    chk({tag, ".first_fail_vec"},   32'(bus2.first_fail_vec),   32'd0);
    chk({tag, ".first_fail_valid"}, 32'(bus2.first_fail_valid), 32'd0);
    chk({tag, ".state"},            32'(bus2.dbg_state),        32'(GC_IDLE));
`ifdef GATE_CHK_LOG_EN
    chk({tag, ".observed_tt"},      32'(bus2.observed_tt),      32'd0);
`endif
  endtask

  // Pulse start for one cycle; queue the expected outcome when the sweep should finish.
  task automatic run2(input logic [3:0] tt, input int mode, input bit expect_done,
                      input bit pass_e, input int err_e, input int ffvec_e, input bit ffv_e,
                      input logic [7:0] obs_e);
    logic [15:0] lat;
    lat   = 16'd12;
    mode2 = mode;
    @(negedge clk);
    bus2.exp_tt = tt;
    bus2.start  = 1'b1;
    if (expect_done) exp_q2.push_back({obs_e, lat, pass_e, ffv_e, 4'(ffvec_e), 5'(err_e)});
    @(posedge clk);
    #1;
    start_cyc2 = cyc;
    bus2.start = 1'b0;
    seq_err2   = 0;
    active2    = expect_done;
    @(negedge clk);
    chk("busy_after_start2", 32'(bus2.busy),      32'd1);
    chk("done_cleared2",     32'(bus2.done),      32'd0);
    chk("err_cleared2",      32'(bus2.err_count), 32'd0);
  endtask

  task automatic drain2();
    int n;
    n = 0;
    while (exp_q2.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain2_pending", 32'(exp_q2.size()), 32'd0);
    exp_q2.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    logic [15:0] lat3;
    bus2.start = 1'b0; bus2.exp_tt = '0;
    bus3.start = 1'b0; bus3.exp_tt = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset2("in_reset");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk_reset2("idle");
    chk("idle3.dut_in", 32'(bus3.dut_in), 32'd0);
    chk("idle3.done",   32'(bus3.done),   32'd0);

    // Healthy xnor, then wrong gate (xor), then stuck-at-1 output; each restarts from DONE.
    run2(TT_XNOR2, 0, 1, 1'b1, 0, 0, 1'b0, 8'h09);
    drain2();
    run2(TT_XNOR2, 1, 1, 1'b0, 4, 0, 1'b1, 8'h06);
    drain2();
    run2(TT_XNOR2, 2, 1, 1'b0, 2, 1, 1'b1, 8'h0F);
    drain2();

    // Mid-sweep start with a different table must neither restart nor relatch.
    run2(TT_XNOR2, 0, 1, 1'b1, 0, 0, 1'b0, 8'h09);
    repeat (4) @(negedge clk);
    bus2.start  = 1'b1;
    bus2.exp_tt = 4'b0000;
    @(negedge clk);
    bus2.start  = 1'b0;
    drain2();

    // Reset during vector 2 SETTLE, together with a start that must lose to rst.
    run2(TT_XNOR2, 0, 0, 1'b0, 0, 0, 1'b0, 8'h00);
    n = 0;
    while (bus2.dut_in !== 2'd2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vec2", 32'(bus2.dut_in), 32'd2);
    chk("mid_sweep_busy", 32'(bus2.busy), 32'd1);
    rst        = 1'b1;
    bus2.start = 1'b1;
    @(negedge clk);
    chk_reset2("mid_reset");
    rst        = 1'b0;
    bus2.start = 1'b0;
    @(negedge clk);
    chk("after_reset_state", 32'(bus2.dbg_state), 32'(GC_IDLE));
    run2(TT_XNOR2, 0, 1, 1'b1, 0, 0, 1'b0, 8'h09);
    drain2();

    // 3-input AND with SETTLE_CYCLES=1: done driven 8*2 edges after accept.
    lat3 = 16'd16;
    @(negedge clk);
    bus3.exp_tt = 8'h80;
    bus3.start  = 1'b1;
    exp_q3.push_back({8'h80, lat3, 1'b1, 1'b0, 4'd0, 5'd0});
    @(posedge clk);
    #1;
    start_cyc3 = cyc;
    bus3.start = 1'b0;
    seq_err3   = 0;
    active3    = 1;
    n = 0;
    while (exp_q3.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain3_pending", 32'(exp_q3.size()), 32'd0);
    chk("done3_held", 32'(bus3.done), 32'd1);

    repeat (3) @(negedge clk);
    chk("done2_held", 32'(bus2.done), 32'd1);
    chk("dut_in2_last", 32'(bus2.dut_in), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
